// File: rtl/fifo_bank_drainer.sv
// Read-side master for a four-bank FIFO: occupancy tracking, round-robin read issue, tagged output stream.
// Latency: wr_evt -> occ next edge, rd_en one edge later, out_valid one cycle after valid_in.
// Backpressure: out_ready low fills the output buffer; reads stop once buffered+in-flight words reach OBUF_DEPTH.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   enable, bank_mask     issue gate and per-bank selection mask
//   wr_evt                one-hot-per-bank write events from the FIFO write side
//   rd_en, rd_id          registered read strobe and bank id to the FIFO read port
//   data_in, valid_in     FIFO read data and its valid, RD_LAT cycles after rd_en
//   out_valid/ready/data/bank  downstream valid/ready stream tagged with source bank
//   occ                   {occ3,occ2,occ1,occ0}, 4 bits per bank
//   err_ovf, err_spur     sticky error flags, cleared only by rst
module fifo_bank_drainer #(
  parameter int DEPTH      = 8,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  bank_mask,
  input  logic [3:0]  wr_evt,
  output logic        rd_en,
  output logic [1:0]  rd_id,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [1:0]  out_bank,
  output logic [15:0] occ,
  output logic        err_ovf,
  output logic        err_spur
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [3:0]  OCC_MAX = 4'(DEPTH);
  localparam logic [CW:0] CREDITS = (CW + 1)'(OBUF_DEPTH);

  // The credit scheme only covers the read pipeline if the buffer can hold
  // every word that may be in flight plus one being presented downstream.
  if (RD_LAT < 1 || OBUF_DEPTH < RD_LAT + 1 || DEPTH < 1 || DEPTH > 15) begin : g_bad_params
    $error("fifo_bank_drainer: illegal parameter combination");
  end

  typedef struct packed {
    logic [1:0] bank;
    logic [7:0] dat;
  } obuf_ent_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-bank occupancy
  // ---------------------------------------------------------------------------
  logic [3:0] occ_q [4];
  logic [3:0] occ_d [4];
  logic [3:0] rd_hit;
  logic [3:0] avail;
  logic [3:0] eligible;
  logic       ovf_set;

  assign rd_hit = rd_en ? (4'b0001 << rd_id) : 4'b0000;

  always_comb begin
    ovf_set = 1'b0;
    for (int b = 0; b < 4; b++) begin
      occ_d[b] = occ_q[b];
      // A bank is worth another read only if words remain once the read
      // already on the port this cycle is accounted for; this is what makes
      // back-to-back reads of one bank safe without over-reading it.
      avail[b] = rd_hit[b] ? (occ_q[b] > 4'd1) : (occ_q[b] != 4'd0);
      if (wr_evt[b] && !rd_hit[b]) begin
        if (occ_q[b] == OCC_MAX) begin
          ovf_set = 1'b1;
        end else begin
          occ_d[b] = occ_q[b] + 4'd1;
        end
      end else if (rd_hit[b] && !wr_evt[b] && occ_q[b] != 4'd0) begin
        occ_d[b] = occ_q[b] - 4'd1;
      end
    end
  end

  assign eligible = avail & bank_mask;
  assign occ      = {occ_q[3], occ_q[2], occ_q[1], occ_q[0]};

  // ---------------------------------------------------------------------------
  // Round-robin selection and credit check
  // ---------------------------------------------------------------------------
  logic [1:0]    rr_ptr;
  logic [1:0]    sel_id;
  logic          sel_found;
  logic          credit_ok;
  logic          issue;
  logic [CW-1:0] tag_cnt;
  logic [CW-1:0] buf_cnt;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!sel_found && eligible[2'(rr_ptr + 2'(k))]) begin
        sel_found = 1'b1;
        sel_id    = 2'(rr_ptr + 2'(k));
      end
    end
  end

  // Every issued read holds a tag until its data returns and then a buffer
  // slot until downstream takes it, so tags + buffered words bound the
  // buffer fill. Pops this cycle are not credited until next cycle.
  assign credit_ok = ({1'b0, buf_cnt} + {1'b0, tag_cnt}) < CREDITS;
  assign issue     = enable && sel_found && credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        occ_q[b] <= '0;
      end
      rd_en    <= 1'b0;
      rd_id    <= 2'd0;
      rr_ptr   <= 2'd0;
      err_ovf  <= 1'b0;
      err_spur <= 1'b0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        occ_q[b] <= occ_d[b];
      end
      rd_en <= issue;
      // rd_id keeps its last value while idle; it is only meaningful with rd_en.
      if (issue) begin
        rd_id  <= sel_id;
        rr_ptr <= sel_id + 2'd1;
      end
      if (ovf_set) begin
        err_ovf <= 1'b1;
      end
      if (valid_in && tag_cnt == '0) begin
        err_spur <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tag queue: bank id of each outstanding read, in issue order
  // ---------------------------------------------------------------------------
  logic [1:0]    tag_mem [OBUF_DEPTH];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic          tag_pop;

  // Returned data with no outstanding tag is dropped (and flagged above).
  assign tag_pop = valid_in && (tag_cnt != '0);

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[tag_wr_ptr] <= sel_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (issue) begin
        tag_wr_ptr <= ptr_inc(tag_wr_ptr);
      end
      if (tag_pop) begin
        tag_rd_ptr <= ptr_inc(tag_rd_ptr);
      end
      case ({issue, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CW'(1);
        2'b01:   tag_cnt <= tag_cnt - CW'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  obuf_ent_t     obuf_mem [OBUF_DEPTH];
  obuf_ent_t     obuf_head;
  logic [PW-1:0] obuf_wr_ptr;
  logic [PW-1:0] obuf_rd_ptr;
  logic          obuf_push;
  logic          obuf_pop;

  assign obuf_push = tag_pop;
  assign obuf_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (obuf_push) begin
      obuf_mem[obuf_wr_ptr] <= '{bank: tag_mem[tag_rd_ptr], dat: data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_wr_ptr <= '0;
      obuf_rd_ptr <= '0;
      buf_cnt     <= '0;
    end else begin
      if (obuf_push) begin
        obuf_wr_ptr <= ptr_inc(obuf_wr_ptr);
      end
      if (obuf_pop) begin
        obuf_rd_ptr <= ptr_inc(obuf_rd_ptr);
      end
      case ({obuf_push, obuf_pop})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // The storage array is not reset, so the head is masked while empty to
  // present zeros after reset.
  assign obuf_head = obuf_mem[obuf_rd_ptr];
  assign out_valid = (buf_cnt != '0);
  assign out_data  = out_valid ? obuf_head.dat  : 8'd0;
  assign out_bank  = out_valid ? obuf_head.bank : 2'd0;

endmodule
